// File: rtl/lif_integrator.sv
// ---------------------------------------------------------------------------
// lif_integrator
//
// Leaky integrate-and-fire stage. It detects rising edges on the upstream
// spike lines and weights each one with a signed per-input weight. The
// weighted sum is added to a membrane potential, which leaks by
// potential >> LEAK_SHIFT every enabled cycle. When the clamped potential
// reaches THRESH, the block fires a one-cycle spike and resets the
// potential. It then sits out REFRACT enabled cycles before it integrates
// again. A saturating 8-bit counter records how many times the block fired.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-high; dominates every other input
//   enable       1 = integrate/advance, 0 = freeze potential/state/count
//   spike_in     N_IN upstream spike levels
//   weight       N_IN signed weights, weight i = [i*W_WIDTH +: W_WIDTH]
//   spike_out    registered one-cycle firing pulse
//   potential    registered membrane potential (unsigned)
//   refractory   high while the block is in its refractory period
//   spike_count  output spikes since reset, saturating at 255
// ---------------------------------------------------------------------------
module lif_integrator #(
  parameter int N_IN       = 4,
  parameter int W_WIDTH    = 4,
  parameter int V_WIDTH    = 8,
  parameter int THRESH     = 64,
  parameter int LEAK_SHIFT = 3,
  parameter int REFRACT    = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [N_IN-1:0]           spike_in,
  input  logic [N_IN*W_WIDTH-1:0]   weight,
  output logic                      spike_out,
  output logic [V_WIDTH-1:0]        potential,
  output logic                      refractory,
  output logic [7:0]                spike_count
);

  // Headroom: one extra bit beyond W_WIDTH + clog2(N_IN) so that the most
  // negative weights can be summed without overflow.
  localparam int SUM_W = W_WIDTH + $clog2(N_IN) + 1;
  // Two extra bits hold the sign and one carry above the V_WIDTH range.
  localparam int NXT_W = V_WIDTH + 2;
  localparam int CNT_W = (REFRACT > 0) ? $clog2(REFRACT + 1) : 1;
  localparam logic [V_WIDTH-1:0] THRESH_V = V_WIDTH'(THRESH);

  typedef enum logic {
    ST_INTEGRATE = 1'b0,
    ST_REFRACT   = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [N_IN-1:0]    prev_q, prev_d;
  logic [V_WIDTH-1:0] pot_q, pot_d;
  logic               spike_q, spike_d;
  logic [7:0]         count_q, count_d;

  logic [N_IN-1:0]         edges;
  logic signed [SUM_W-1:0] sum;
  logic [V_WIDTH-1:0]      leaked;
  logic signed [NXT_W-1:0] next_raw;
  logic [V_WIDTH-1:0]      clamped;
  logic                    fire;

  // Datapath: edge detection, weighted sum, leak, clamp, threshold test.
  always_comb begin
    // NOTE: every variable written here gets a default value first. Each
    // path through the block then assigns it, so no latch is inferred.
    sum = '0;
    edges = spike_in & ~prev_q;
    for (int i = 0; i < N_IN; i++) begin
      if (edges[i]) begin
        sum = sum + SUM_W'($signed(weight[i*W_WIDTH +: W_WIDTH]));
      end
    end

    // The leak can never underflow: pot_q >> LEAK_SHIFT is at most pot_q.
    leaked   = pot_q - (pot_q >> LEAK_SHIFT);
    next_raw = $signed({2'b00, leaked}) + NXT_W'(sum);

    // Clamp into [0, 2^V_WIDTH-1]. A set top bit means the value is
    // negative. Any set bit between the sign bit and V_WIDTH means the
    // value is above the range.
    if (next_raw[NXT_W-1]) begin
      clamped = '0;
    end else if (|next_raw[NXT_W-2:V_WIDTH]) begin
      clamped = '1;
    end else begin
      clamped = next_raw[V_WIDTH-1:0];
    end

    fire = (clamped >= THRESH_V);
  end

  // Next-state logic.
  always_comb begin
    // The edge history tracks the inputs every cycle, even when the block
    // is frozen or refractory. Edges in those cycles are therefore dropped,
    // not deferred.
    prev_d  = spike_in;
    spike_d = 1'b0;
    pot_d   = pot_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    count_d = count_q;

    if (enable) begin
      unique case (state_q)
        ST_INTEGRATE: begin
          if (fire) begin
            pot_d   = '0;
            spike_d = 1'b1;
            if (count_q != 8'hFF) begin
              count_d = count_q + 8'd1;
            end
            if (REFRACT > 0) begin
              state_d = ST_REFRACT;
              cnt_d   = CNT_W'(REFRACT);
            end
          end else begin
            pot_d = clamped;
          end
        end
        ST_REFRACT: begin
          pot_d = '0;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            state_d = ST_INTEGRATE;
          end
        end
        default: state_d = ST_INTEGRATE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state is updated with non-blocking assignments. All
    // flops then sample the previous cycle's values together, and the
    // result does not depend on the order of the statements.
    if (reset) begin
      state_q <= ST_INTEGRATE;
      cnt_q   <= '0;
      prev_q  <= '0;
      pot_q   <= '0;
      spike_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prev_q  <= prev_d;
      pot_q   <= pot_d;
      spike_q <= spike_d;
      count_q <= count_d;
    end
  end

  assign spike_out   = spike_q;
  assign potential   = pot_q;
  assign refractory  = (state_q == ST_REFRACT);
  assign spike_count = count_q;

endmodule

// File: tb/tb_lif_integrator.sv
// ---------------------------------------------------------------------------
// tb_lif_integrator
//
// Directed, table-driven bench for lif_integrator. The main instance uses
// the default parameters: THRESH=64, LEAK_SHIFT=3 and REFRACT=4. A second
// instance uses THRESH=16 and REFRACT=0, so it fires on every input edge;
// it drives spike_count into saturation.
// ---------------------------------------------------------------------------
module tb_lif_integrator;

  localparam logic [15:0] W7  = 16'h7777;  // all weights +7
  localparam logic [15:0] WN  = 16'h8888;  // all weights -8
  localparam logic [15:0] WM  = 16'h8777;  // {7,7,7,-8}, input 3 is -8
  localparam logic [15:0] W25 = 16'h4777;  // {7,7,7,4}, sum 25

  logic        clk = 1'b0;
  logic        rst, en;
  logic [3:0]  si;
  logic [15:0] w;
  logic        spike_out, refractory;
  logic [7:0]  potential, spike_count;

  logic        f_rst, f_en;
  logic [3:0]  f_si;
  logic [15:0] f_w;
  logic        f_spike_out, f_refractory;
  logic [7:0]  f_potential, f_spike_count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  lif_integrator u_dut (
    .clk         (clk),
    .reset       (rst),
    .enable      (en),
    .spike_in    (si),
    .weight      (w),
    .spike_out   (spike_out),
    .potential   (potential),
    .refractory  (refractory),
    .spike_count (spike_count)
  );

  lif_integrator #(.THRESH(16), .REFRACT(0)) u_fast (
    .clk         (clk),
    .reset       (f_rst),
    .enable      (f_en),
    .spike_in    (f_si),
    .weight      (f_w),
    .spike_out   (f_spike_out),
    .potential   (f_potential),
    .refractory  (f_refractory),
    .spike_count (f_spike_count)
  );

  typedef struct {
    logic        rst;
    logic        en;
    logic [3:0]  si;
    logic [15:0] w;
    logic        spk;
    logic [7:0]  pot;
    logic        refr;
    logic [7:0]  cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, input logic e, input logic [3:0] s,
                              input logic [15:0] ww, input logic sp,
                              input logic [7:0] p, input logic rf,
                              input logic [7:0] c);
    vec_t v;
    v.rst = r; v.en = e; v.si = s; v.w = ww;
    v.spk = sp; v.pot = p; v.refr = rf; v.cnt = c;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, let the edge pass, and compare all outputs.
  task automatic run(input string name, input logic r, input logic e,
                     input logic [3:0] s, input logic [15:0] ww,
                     input logic sp, input logic [7:0] p, input logic rf,
                     input logic [7:0] c);
    rst = r; en = e; si = s; w = ww;
    @(posedge clk);
    #1;
    check({name, " spike_out"},   32'(spike_out),   32'(sp));
    check({name, " potential"},   32'(potential),   32'(p));
    check({name, " refractory"},  32'(refractory),  32'(rf));
    check({name, " spike_count"}, 32'(spike_count), 32'(c));
  endtask

  task automatic fast_step(input logic [3:0] s);
    f_si = s;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int pulses;
    int fast_refr_seen;
    rst = 1'b1; en = 1'b1; si = 4'h0; w = W7;
    f_rst = 1'b1; f_en = 1'b1; f_si = 4'h0; f_w = W7;

    //   rst en  si    w    spk pot refr cnt
    // Reset with the inputs high, then one integration only (prev was 0).
    add(1, 1, 4'hF, W7,   0,  0, 0, 0);
    add(1, 1, 4'hF, W7,   0,  0, 0, 0);
    add(0, 1, 4'hF, W7,   0, 28, 0, 0);
    add(0, 1, 4'hF, W7,   0, 25, 0, 0);
    add(0, 1, 4'hF, W7,   0, 22, 0, 0);
    // Integrate to fire while the inputs toggle: 28, 25, 50, 44, then fire (67).
    add(1, 1, 4'h0, W7,   0,  0, 0, 0);
    add(1, 1, 4'h0, W7,   0,  0, 0, 0);
    add(0, 1, 4'hF, W7,   0, 28, 0, 0);
    add(0, 1, 4'h0, W7,   0, 25, 0, 0);
    add(0, 1, 4'hF, W7,   0, 50, 0, 0);
    add(0, 1, 4'h0, W7,   0, 44, 0, 0);
    add(0, 1, 4'hF, W7,   1,  0, 1, 1);
    // Refractory for 4 cycles; the edge in the third refractory cycle is ignored.
    add(0, 1, 4'hF, W7,   0,  0, 1, 1);
    add(0, 1, 4'h0, W7,   0,  0, 1, 1);
    add(0, 1, 4'hF, W7,   0,  0, 1, 1);
    add(0, 1, 4'h0, W7,   0,  0, 0, 1);
    add(0, 1, 4'hF, W7,   0, 28, 0, 1);
    add(0, 1, 4'h0, W7,   0, 25, 0, 1);
    add(0, 1, 4'hF, W7,   0, 50, 0, 1);
    add(0, 1, 4'h0, W7,   0, 44, 0, 1);
    // Freeze at 44 for 5 cycles with toggling inputs.
    add(0, 0, 4'hF, W7,   0, 44, 0, 1);
    add(0, 0, 4'h0, W7,   0, 44, 0, 1);
    add(0, 0, 4'hF, W7,   0, 44, 0, 1);
    add(0, 0, 4'h0, W7,   0, 44, 0, 1);
    add(0, 0, 4'hF, W7,   0, 44, 0, 1);
    // The input level was already high during the freeze: no edge, leak only.
    add(0, 1, 4'hF, W7,   0, 39, 0, 1);
    add(0, 1, 4'h0, W7,   0, 35, 0, 1);
    // Mixed weights from 50: 50 - 6 + 13 = 57 (a frozen cycle clears prev).
    add(1, 1, 4'h0, W7,   0,  0, 0, 0);
    add(0, 1, 4'hF, W7,   0, 28, 0, 0);
    add(0, 1, 4'h0, W7,   0, 25, 0, 0);
    add(0, 1, 4'hF, W7,   0, 50, 0, 0);
    add(0, 0, 4'h0, W7,   0, 50, 0, 0);
    add(0, 1, 4'hF, WM,   0, 57, 0, 0);
    // Inhibition: -32 from 0 clamps to 0, no spike.
    add(1, 1, 4'h0, WN,   0,  0, 0, 0);
    add(0, 1, 4'hF, WN,   0,  0, 0, 0);
    add(0, 1, 4'h0, WN,   0,  0, 0, 0);
    // A potential of exactly THRESH fires: 44 - 5 + 25 = 64.
    add(0, 1, 4'hF, W7,   0, 28, 0, 0);
    add(0, 1, 4'h0, W7,   0, 25, 0, 0);
    add(0, 1, 4'hF, W7,   0, 50, 0, 0);
    add(0, 1, 4'h0, W7,   0, 44, 0, 0);
    add(0, 1, 4'hF, W25,  1,  0, 1, 1);
    add(0, 1, 4'h0, W7,   0,  0, 1, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      run($sformatf("row%0d", i), vecs[i].rst, vecs[i].en, vecs[i].si,
          vecs[i].w, vecs[i].spk, vecs[i].pot, vecs[i].refr, vecs[i].cnt);
    end

    // Reset 2 cycles into REFRACT: back to INTEGRATE at once. The input held
    // high across the reset then counts as a fresh edge.
    run("mr0", 1, 1, 4'h0, W7, 0,  0, 0, 0);
    run("mr1", 0, 1, 4'hF, W7, 0, 28, 0, 0);
    run("mr2", 0, 1, 4'h0, W7, 0, 25, 0, 0);
    run("mr3", 0, 1, 4'hF, W7, 0, 50, 0, 0);
    run("mr4", 0, 1, 4'h0, W7, 0, 44, 0, 0);
    run("mr5", 0, 1, 4'hF, W7, 1,  0, 1, 1);
    run("mr6", 0, 1, 4'h0, W7, 0,  0, 1, 1);
    run("mr7", 0, 1, 4'hF, W7, 0,  0, 1, 1);
    run("mr8", 1, 1, 4'hF, W7, 0,  0, 0, 0);
    run("mr9", 0, 1, 4'hF, W7, 0, 28, 0, 0);

    // Saturation: THRESH=16 and REFRACT=0, so every rising edge fires.
    f_rst = 1'b1;
    fast_step(4'h0);
    f_rst = 1'b0;
    pulses = 0;
    fast_refr_seen = 0;
    for (int k = 1; k <= 300; k++) begin
      fast_step(4'hF);
      if (f_spike_out) pulses++;
      if (f_refractory) fast_refr_seen++;
      if (k == 1 || k == 254 || k == 255 || k == 256 || k == 300) begin
        check($sformatf("sat k=%0d spike_count", k), 32'(f_spike_count),
              (k > 255) ? 32'd255 : 32'(k));
        check($sformatf("sat k=%0d potential", k), 32'(f_potential), 32'd0);
      end
      fast_step(4'h0);
      if (f_spike_out) pulses++;
      if (f_refractory) fast_refr_seen++;
    end
    check("sat pulse total", 32'(pulses), 32'd300);
    check("sat refractory never set", 32'(fast_refr_seen), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/lif_integrator.md
# lif_integrator

Leaky integrate-and-fire stage that sits directly downstream of the oscillator neurons. It consumes their spike outputs, weights each rising edge, and integrates them into a leaky membrane potential. When the potential crosses a threshold, the block emits a one-cycle spike, then enters a refractory period, which couples oscillators into a network. It also keeps a saturating count of its own output spikes for debug readout.

## Interface
- N_IN, 4: number of upstream spike inputs
- W_WIDTH, 4: per-input weight width, signed two's complement
- V_WIDTH, 8: membrane potential width, unsigned
- THRESH, 64: firing threshold; fire when potential ≥ THRESH
- LEAK_SHIFT, 3: leak per cycle = potential >> LEAK_SHIFT
- REFRACT, 4: refractory length in enabled cycles; 0 = none

- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- enable  in  1  1 = integrate/advance; 0 = freeze state
- spike_in  in  N_IN  spike levels from upstream neurons; bit i = neuron i
- weight  in  N_IN*W_WIDTH  weight i = bits [i*W_WIDTH +: W_WIDTH], signed
- spike_out  out  1  one-cycle output spike pulse, registered
- potential  out  V_WIDTH  current membrane potential, registered
- refractory  out  1  high while in REFRACT state
- spike_count  out  8  output spikes since reset, saturates at 255

## Operation
- Edge detect: per-input register prev_i samples spike_in every cycle, regardless of enable or state.
  - edge_i = spike_in[i] & ~prev_i.
  - A level held high contributes only once.
- States: INTEGRATE, REFRACT.
- INTEGRATE, enable=1:
  - sum = signed sum of weight_i over inputs with edge_i. Computed in at least W_WIDTH+clog2(N_IN) bits.
  - next = potential − (potential >> LEAK_SHIFT) + sum, evaluated signed in V_WIDTH+2 bits.
  - Clamp next to [0, 2^V_WIDTH−1].
  - If clamped next ≥ THRESH: potential←0, spike_out←1, spike_count += 1 (saturating). If REFRACT>0, go to REFRACT with counter←REFRACT; otherwise stay in INTEGRATE.
  - Otherwise: potential←clamped next, spike_out←0.
- REFRACT, enable=1:
  - potential held at 0 and edges ignored (prev_i still updates).
  - counter decrements each cycle; when counter==1, go to INTEGRATE on the next edge.
  - The block therefore spends exactly REFRACT enabled cycles in REFRACT.
- enable=0: potential, state, counter and spike_count all hold. spike_out←0. Edges arriving in that cycle are lost.
- Reset dominates enable and all other inputs.

## Timing
- Reset values:
  - spike_out=0, potential=0, refractory=0, spike_count=0
  - state=INTEGRATE, counter=0, all prev_i=0
- Input edge sampled at clock edge k → potential and spike_out reflect it after edge k (1-cycle latency).
- spike_out is high for exactly one cycle per firing. Minimum spacing between pulses is REFRACT+1 cycles.
- refractory goes high the cycle after the firing edge and stays high for REFRACT enabled cycles.
- An input already high when reset deasserts counts as an edge on the first enabled cycle after reset, because prev_i=0.
- Reset during REFRACT: return to INTEGRATE immediately with counter cleared and no spike.
- Edges that coincide with the firing cycle are part of that cycle's sum and do not carry over.
- Threshold comparison is done after clamping.

## Test plan
- Reset: drive reset=1 for 2 cycles with spike_in=4'hF → all outputs 0, state INTEGRATE.
  - After release with spike_in held at F, exactly one integration occurs (potential=28 with all weights 7), then no further change apart from leak.
- Integrate-to-fire, all weights=7, spike_in toggling F/0 every cycle from potential 0:
  - potential sequence 28, 25, 50, 44, then spike_out=1 on the third rising edge (next=67), with potential=0 and spike_count=1.
- Refractory, REFRACT=4, continue the toggling after the first spike:
  - refractory high for exactly 4 cycles, potential stays 0, no edges integrated.
  - Integration resumes on the 5th cycle.
- Inhibition and clamp: all weights=−8, single edge F at potential 0 → potential stays 0 (−32 clamped), no spike.
  - Mixed case: weights {7,7,7,−8} from potential 50 → 50 − 6 + 13 = 57.
- Enable freeze: deassert enable mid-integration at potential=44 for 5 cycles with toggling inputs → potential stays 44, spike_out stays 0.
  - Edges during that window are not integrated.
- Reset mid-refractory and counter saturation:
  - reset asserted 2 cycles into REFRACT → refractory=0 the cycle after reset.
  - Force 300 firings (weights 7, THRESH=16) → spike_count=255, not wrapping.
